// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit_pkg
// Description : Shared CPU definitions used by the instruction fetch slice:
//               fetch FSM state encoding, kseg segment tags and the physical
//               address mask applied to unmapped kernel segments.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_unit_pkg;

    // Fetch FSM states; at most one bus request is ever outstanding.
    typedef enum logic [1:0] {
        ST_REQ       = 2'd0,  // present a request for pc_i
        ST_WAIT_DATA = 2'd1,  // address accepted, waiting for data
        ST_HOLD      = 2'd2,  // data captured while decode was stalled
        ST_DISCARD   = 2'd3   // drain a response that belongs to a dead PC
    } fetch_state_e;

    // Top three address bits identifying the unmapped kernel segments.
    localparam logic [2:0]  KSEG0_SEG = 3'b100;
    localparam logic [2:0]  KSEG1_SEG = 3'b101;

    // Strips the segment bits, leaving the physical address.
    localparam logic [31:0] ADDR_MASK = 32'h1FFF_FFFF;

endpackage : inst_fetch_unit_pkg
`default_nettype wire

// File: rtl/inst_fetch_unit_addr_map.sv
`default_nettype none
// ============================================================================
// Module      : inst_addr_map
// Description : Combinational virtual-to-physical translation for fetch.
//               kseg0/kseg1 addresses have their segment bits cleared; all
//               other addresses pass through unchanged.
// Ports       : pc_i   - virtual fetch address
//               addr_o - physical address for the bus
// Revision    : 1.0 - initial release
// ============================================================================
module inst_addr_map
    import inst_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] addr_o
);

    logic [2:0] w_seg;

    assign w_seg = pc_i[WIDTH-1 -: 3];

    always_comb begin
        addr_o = pc_i;
        if ((w_seg == KSEG0_SEG) || (w_seg == KSEG1_SEG)) begin
            addr_o = pc_i & WIDTH'(ADDR_MASK);
        end
    end

endmodule : inst_addr_map
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Instruction fetch stage. Issues one sram-like request at a
//               time for pc_i, buffers data when decode stalls, drops stale
//               responses after a flush and raises an address-error for
//               misaligned PCs. IF/ID outputs are registered.
// Ports       : clk, rst (async, active-high)
//               pc_i / pc_en_o          - PC register value / advance enable
//               flush_i, stall_i        - redirect and decode back-pressure
//               inst_req, inst_addr     - bus request channel
//               inst_addr_ok, inst_data_ok, inst_rdata - bus response channel
//               id_valid_o, id_pc_o, id_inst_o, id_adel_o - IF/ID register
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    output logic             pc_en_o,
    input  logic             flush_i,
    input  logic             stall_i,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             id_valid_o,
    output logic [WIDTH-1:0] id_pc_o,
    output logic [WIDTH-1:0] id_inst_o,
    output logic             id_adel_o
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             id_valid_q, id_valid_d;
    logic [WIDTH-1:0] id_pc_q, id_pc_d;
    logic [WIDTH-1:0] id_inst_q, id_inst_d;
    logic             id_adel_q, id_adel_d;

    logic             w_req;
    logic             w_pc_en;
    logic             w_aligned;

    assign w_aligned = (pc_i[1:0] == 2'b00);

    inst_addr_map #(
        .WIDTH (WIDTH)
    ) u_addr_map (
        .pc_i   (pc_i),
        .addr_o (inst_addr)
    );

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        w_req      = 1'b0;
        w_pc_en    = 1'b0;
        // Stalled decode keeps its instruction; otherwise the slot empties
        // unless something below loads it.
        id_valid_d = stall_i ? id_valid_q : 1'b0;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_adel_d  = id_adel_q;

        case (state_q)
            ST_REQ: begin
                if (flush_i) begin
                    // Request is withdrawn, but an addr_ok in this cycle
                    // still leaves a response in flight that must be drained.
                    if (inst_addr_ok) begin
                        state_d = ST_DISCARD;
                    end
                end else if (w_aligned) begin
                    w_req = 1'b1;
                    if (inst_addr_ok) begin
                        state_d = ST_WAIT_DATA;
                    end
                end else if (!stall_i) begin
                    // Misaligned fetch: no bus access, pass the exception on.
                    id_valid_d = 1'b1;
                    id_pc_d    = pc_i;
                    id_inst_d  = '0;
                    id_adel_d  = 1'b1;
                    w_pc_en    = 1'b1;
                end
            end

            ST_WAIT_DATA: begin
                if (flush_i) begin
                    state_d = inst_data_ok ? ST_REQ : ST_DISCARD;
                end else if (inst_data_ok) begin
                    if (!stall_i) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = pc_i;
                        id_inst_d  = inst_rdata;
                        id_adel_d  = 1'b0;
                        w_pc_en    = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        buf_d   = inst_rdata;
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (flush_i) begin
                    state_d = ST_REQ;
                end else if (!stall_i) begin
                    // pc_i has not advanced yet, so it still matches buf_q.
                    id_valid_d = 1'b1;
                    id_pc_d    = pc_i;
                    id_inst_d  = buf_q;
                    id_adel_d  = 1'b0;
                    w_pc_en    = 1'b1;
                    state_d    = ST_REQ;
                end
            end

            ST_DISCARD: begin
                if (inst_data_ok) begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (flush_i) begin
            id_valid_d = 1'b0;
            id_adel_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_REQ;
            buf_q      <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_adel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_adel_q  <= id_adel_d;
        end
    end

    // Reset gates the combinational strobes so nothing leaks while held.
    assign inst_req   = w_req & ~rst;
    assign pc_en_o    = w_pc_en & ~rst;
    assign id_valid_o = id_valid_q;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_adel_o  = id_adel_q;

endmodule : inst_fetch_unit
`default_nettype wire
